riscv_ifetch_buffer: RTL and testbench

- Instruction-fetch stage directly upstream of the RISC-V core.
- Sequentially fetches 32-bit instructions from instruction memory over a req/ack handshake and queues them in a small FIFO.
- Presents the head instruction and its PC to the core.
- On a control-flow redirect (branch, jal, jalr) it flushes the FIFO and restarts fetching at the new PC.

---
 rtl/riscv_ifetch_buffer_if.sv | 24 ++
 rtl/riscv_ifetch_buffer.sv | 123 ++++++++++++
 tb/tb_riscv_ifetch_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ifetch_buffer_if.sv
// Core-side and instruction-memory-side signals of the instruction-fetch buffer.
// The master modport is the fetch buffer; the slave modport is the core plus memory that surround it.
interface riscv_ifetch_buffer_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        core_ready;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  redirect, redirect_pc, core_ready, mem_ack, mem_rdata,
        output ir_valid, ir_data, ir_pc, mem_req, mem_addr
    );

    modport slave (
        output redirect, redirect_pc, core_ready, mem_ack, mem_rdata,
        input  ir_valid, ir_data, ir_pc, mem_req, mem_addr
    );
endinterface

// File: rtl/riscv_ifetch_buffer.sv
// RISC-V instruction-fetch stage: sequential single-outstanding fetch into a small FIFO.
// A redirect flushes the queue and discards any in-flight word.
module riscv_ifetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   rst,
    riscv_ifetch_buffer_if.master bus
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_reg;
    logic          req_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   fpc_reg;
    logic [AW:0]   count_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_al;
    logic          unused_pc_bits;

    assign redirect_pc_al = {bus.redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^bus.redirect_pc[1:0];

    // Data is enqueued only while wanted; a redirect on the ack cycle discards it.
    assign push = (state_reg == WAIT) && bus.mem_ack && !bus.redirect;
    assign pop  = (count_reg != '0) && bus.core_ready && !bus.redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            addr_reg  <= RESET_PC;
            fpc_reg   <= RESET_PC;
        end else begin
            if (bus.redirect) begin
                fpc_reg <= redirect_pc_al;
            end
            case (state_reg)
                IDLE: begin
                    if (!bus.redirect && (count_reg < FULL_CNT)) begin
                        req_reg   <= 1'b1;
                        addr_reg  <= fpc_reg;
                        fpc_reg   <= fpc_reg + 32'd4;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (bus.redirect) begin
                        state_reg <= DROP;
                    end
                end
                DROP: begin
                    if (bus.mem_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    req_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else if (bus.redirect) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Queue storage carries no reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= bus.mem_rdata;
            pc_mem[wr_ptr_reg]   <= addr_reg;
        end
    end

    assign bus.ir_valid = (count_reg != '0);
    assign bus.ir_data  = data_mem[rd_ptr_reg];
    assign bus.ir_pc    = pc_mem[rd_ptr_reg];
    assign bus.mem_req  = req_reg;
    assign bus.mem_addr = addr_reg;
endmodule

// File: tb/tb_riscv_ifetch_buffer.sv
// Directed bench for riscv_ifetch_buffer: a default-PC instance with a controllable memory
// and a wrap-around instance (RESET_PC near the top of memory) with a zero-wait memory.
module tb_riscv_ifetch_buffer;
    logic clk;
    logic rst;

    riscv_ifetch_buffer_if if0 ();
    riscv_ifetch_buffer_if if1 ();

    riscv_ifetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );

    riscv_ifetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Memory for dut0: automatic ack after ack_delay waiting cycles, or manual ack.
    logic man_mode;
    logic man_ack;
    int   ack_delay;
    int   wait_cnt;
    int   acks0;
    logic auto_ack;

    assign auto_ack      = if0.mem_req && (wait_cnt >= ack_delay);
    assign if0.mem_ack   = man_mode ? man_ack : auto_ack;
    assign if0.mem_rdata = if0.mem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (!if0.mem_req || if0.mem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
        if (if0.mem_req && if0.mem_ack)  acks0 <= acks0 + 1;
    end

    // Zero-wait memory for dut1, with a log of completed fetch addresses.
    logic [31:0] log1 [8];
    int          n1;

    assign if1.mem_ack   = if1.mem_req;
    assign if1.mem_rdata = if1.mem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (if1.mem_req && if1.mem_ack && n1 < 8) begin
            log1[n1[2:0]] <= if1.mem_addr;
            n1            <= n1 + 1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("  ok %s = %h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        rst             = 1'b1;
        if0.redirect    = 1'b0;
        if0.redirect_pc = 32'h0;
        if0.core_ready  = 1'b0;
        if1.redirect    = 1'b0;
        if1.redirect_pc = 32'h0;
        if1.core_ready  = 1'b1;
        man_mode        = 1'b0;
        man_ack         = 1'b0;
        ack_delay       = 0;

        tick(2);
        check_vec("rst_ir_valid", 32'(if0.ir_valid), 32'h0);
        check_vec("rst_mem_req", 32'(if0.mem_req), 32'h0);
        check_vec("rst_mem_addr", if0.mem_addr, 32'h0000_0000);
        check_vec("rst_mem_req_hi", 32'(if1.mem_req), 32'h0);
        check_vec("rst_mem_addr_hi", if1.mem_addr, 32'hFFFF_FFF8);

        // Sequential fetch, zero-wait memory, core always ready.
        if0.core_ready = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check_vec($sformatf("seq_req_%0d", k), 32'(if0.mem_req), 32'h1);
            check_vec($sformatf("seq_addr_%0d", k), if0.mem_addr, 32'(4 * k));
            tick(1);
            check_vec($sformatf("seq_valid_%0d", k), 32'(if0.ir_valid), 32'h1);
            check_vec($sformatf("seq_pc_%0d", k), if0.ir_pc, 32'(4 * k));
            check_vec($sformatf("seq_data_%0d", k), if0.ir_data, 32'(4 * k) ^ 32'hA5A5_0000);
        end

        // Wrap-around instance fetched during the same window.
        check_vec("wrap_n", 32'(n1 >= 3), 32'h1);
        check_vec("wrap_addr_0", log1[0], 32'hFFFF_FFF8);
        check_vec("wrap_addr_1", log1[1], 32'hFFFF_FFFC);
        check_vec("wrap_addr_2", log1[2], 32'h0000_0000);

        // Core stalled: fill to DEPTH, then drain in order and resume at 0x10.
        if0.core_ready = 1'b0;
        do_reset();
        base = acks0;
        tick(20);
        check_vec("full_acks", 32'(acks0 - base), 32'd4);
        check_vec("full_req", 32'(if0.mem_req), 32'h0);
        check_vec("full_head_pc", if0.ir_pc, 32'h0);
        if0.core_ready = 1'b1;
        tick(1);
        check_vec("drain_pc_1", if0.ir_pc, 32'h4);
        check_vec("drain_req_1", 32'(if0.mem_req), 32'h0);
        tick(1);
        check_vec("drain_pc_2", if0.ir_pc, 32'h8);
        check_vec("drain_req_2", 32'(if0.mem_req), 32'h1);
        check_vec("drain_addr_2", if0.mem_addr, 32'h10);
        tick(1);
        check_vec("drain_pc_3", if0.ir_pc, 32'hC);
        tick(1);
        check_vec("drain_pc_4", if0.ir_pc, 32'h10);
        check_vec("drain_data_4", if0.ir_data, 32'hA5A5_0010);
        check_vec("drain_valid_4", 32'(if0.ir_valid), 32'h1);

        // Redirect while waiting on a slow ack: in-flight word dropped.
        ack_delay = 3;
        do_reset();
        tick(1);
        check_vec("drop_req_0", 32'(if0.mem_req), 32'h1);
        if0.redirect    = 1'b1;
        if0.redirect_pc = 32'h0000_0103;
        tick(1);
        if0.redirect = 1'b0;
        check_vec("drop_req_held", 32'(if0.mem_req), 32'h1);
        check_vec("drop_addr_held", if0.mem_addr, 32'h0);
        tick(2);
        check_vec("drop_addr_stable", if0.mem_addr, 32'h0);
        tick(1);
        check_vec("drop_req_done", 32'(if0.mem_req), 32'h0);
        check_vec("drop_valid_done", 32'(if0.ir_valid), 32'h0);
        tick(1);
        check_vec("drop_new_addr", if0.mem_addr, 32'h0000_0100);
        check_vec("drop_new_valid", 32'(if0.ir_valid), 32'h0);
        ack_delay = 0;
        tick(1);
        check_vec("drop_arrive_valid", 32'(if0.ir_valid), 32'h1);
        check_vec("drop_arrive_pc", if0.ir_pc, 32'h0000_0100);
        check_vec("drop_arrive_data", if0.ir_data, 32'hA5A5_0100);

        // Redirect coinciding with mem_ack while two entries are queued.
        man_mode = 1'b1;
        man_ack = 1'b0;
        if0.core_ready = 1'b0;
        do_reset();
        tick(1);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        tick(1);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check_vec("same_two_valid", 32'(if0.ir_valid), 32'h1);
        check_vec("same_two_pc", if0.ir_pc, 32'h0);
        tick(1);
        check_vec("same_third_addr", if0.mem_addr, 32'h8);
        man_ack = 1'b1;
        if0.redirect = 1'b1;
        if0.redirect_pc = 32'h0000_0200;
        tick(1);
        man_ack = 1'b0;
        if0.redirect = 1'b0;
        check_vec("same_flush_valid", 32'(if0.ir_valid), 32'h0);
        check_vec("same_flush_req", 32'(if0.mem_req), 32'h0);
        tick(1);
        check_vec("same_next_req", 32'(if0.mem_req), 32'h1);
        check_vec("same_next_addr", if0.mem_addr, 32'h0000_0200);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check_vec("same_arrive_pc", if0.ir_pc, 32'h0000_0200);
        check_vec("same_arrive_data", if0.ir_data, 32'hA5A5_0200);

        // Reset in the middle of a request, with a stale ack after release.
        if0.core_ready = 1'b1;
        do_reset();
        if0.redirect = 1'b1;
        if0.redirect_pc = 32'h0000_0300;
        tick(1);
        if0.redirect = 1'b0;
        check_vec("mid_idle_redirect_req", 32'(if0.mem_req), 32'h0);
        tick(1);
        check_vec("mid_req", 32'(if0.mem_req), 32'h1);
        check_vec("mid_addr", if0.mem_addr, 32'h0000_0300);
        #2 rst = 1'b1;
        #1;
        check_vec("mid_async_req", 32'(if0.mem_req), 32'h0);
        check_vec("mid_async_addr", if0.mem_addr, 32'h0);
        check_vec("mid_async_valid", 32'(if0.ir_valid), 32'h0);
        tick(1);
        rst = 1'b0;
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check_vec("stale_valid", 32'(if0.ir_valid), 32'h0);
        check_vec("stale_req", 32'(if0.mem_req), 32'h1);
        check_vec("stale_addr", if0.mem_addr, 32'h0);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check_vec("post_rst_valid", 32'(if0.ir_valid), 32'h1);
        check_vec("post_rst_pc", if0.ir_pc, 32'h0);
        check_vec("post_rst_data", if0.ir_data, 32'hA5A5_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
